// File: rtl/echo_scan_scheduler.sv
// echo_scan_scheduler: round-robin ultrasonic sensor scheduler. Triggers each sensor
// in turn, times its echo pulse, reports one result per sensor and waits a guard gap.
module echo_scan_scheduler #(
  parameter int NUM_SENSORS  = 4,
  parameter int SEL_W        = 2,
  parameter int CNT_W        = 20,
  parameter int ECHO_TIMEOUT = 600000,
  parameter int GUARD_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             start_trigger,
  input  logic             trigger_done,
  output logic [SEL_W-1:0] sensor_sel,
  input  logic             echo_in,
  output logic             meas_valid,
  output logic [SEL_W-1:0] meas_sensor,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_timeout,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    REPORT    = 3'd4,
    GUARD     = 3'd5
  } state_t;

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   TIMER_LAST = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [GUARD_W-1:0] GUARD_ONE  = GUARD_W'(1);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_SENSORS - 1);
  localparam logic [SEL_W-1:0]   SEL_ONE    = SEL_W'(1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic [GUARD_W-1:0] guard_cnt;
  logic               echo_s1, echo_s, echo_s_d;
  logic               echo_rise, echo_fall, timer_last, guard_last;

  // Trigger handshake: start_trigger is a request held high from TRIG entry until
  // trigger_done is sampled high in TRIG; that cycle completes the transfer and the
  // request drops on the next edge. trigger_done seen in any other state is ignored.
  always_comb begin
    state_d    = state;
    echo_rise  = echo_s & ~echo_s_d;
    echo_fall  = ~echo_s & echo_s_d;
    timer_last = (timer == TIMER_LAST);
    guard_last = (guard_cnt == GUARD_LAST);
    count_inc  = (count == CNT_MAX) ? count : count + CNT_ONE;
    case (state)
      IDLE:      if (enable) state_d = TRIG;
      TRIG:      if (trigger_done) state_d = WAIT_ECHO;
      WAIT_ECHO: begin
        if (timer_last)     state_d = REPORT;
        else if (echo_rise) state_d = MEASURE;
      end
      MEASURE:   if (timer_last || echo_fall) state_d = REPORT;
      REPORT:    state_d = GUARD;
      GUARD:     if (guard_last) state_d = enable ? TRIG : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      start_trigger <= 1'b0;
      sensor_sel    <= '0;
      meas_valid    <= 1'b0;
      meas_sensor   <= '0;
      meas_count    <= '0;
      meas_timeout  <= 1'b0;
      timer         <= '0;
      count         <= '0;
      guard_cnt     <= '0;
      echo_s1       <= 1'b0;
      echo_s        <= 1'b0;
      echo_s_d      <= 1'b0;
    end else begin
      state      <= state_d;
      echo_s1    <= echo_in;
      echo_s     <= echo_s1;
      echo_s_d   <= echo_s;
      meas_valid <= 1'b0;
      case (state)
        IDLE: if (enable) start_trigger <= 1'b1;
        TRIG: begin
          if (trigger_done) begin
            start_trigger <= 1'b0;
            timer         <= '0;
            count         <= '0;
          end
        end
        WAIT_ECHO: begin
          timer <= timer + CNT_ONE;
          if (echo_rise) count <= CNT_ONE;
        end
        MEASURE: begin
          timer <= timer + CNT_ONE;
          if (echo_s) count <= count_inc;
        end
        REPORT: guard_cnt <= '0;
        GUARD: begin
          if (guard_last) begin
            sensor_sel    <= (sensor_sel == SEL_LAST) ? '0 : sensor_sel + SEL_ONE;
            start_trigger <= enable;
          end else begin
            guard_cnt <= guard_cnt + GUARD_ONE;
          end
        end
        default: ;
      endcase
      // A high echo on the timeout cycle still counts as one more measured cycle.
      if (state_d == REPORT) begin
        meas_valid   <= 1'b1;
        meas_sensor  <= sensor_sel;
        meas_timeout <= timer_last;
        meas_count   <= (state == MEASURE && echo_s) ? count_inc : count;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_echo_scan_scheduler.sv
// Bench for echo_scan_scheduler: directed shots from the scan scenarios plus random
// echo patterns, each checked against an echo-window model of one measurement.
`timescale 1ns/1ps
module tb_echo_scan_scheduler;
  localparam int NS        = 3;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 8;
  localparam int TO        = 100;
  localparam int GC        = 10;
  localparam int ACK_DELAY = 8;

  // clock / reset block
  logic clk = 1'b0;
  logic reset, enable, trigger_done, echo_in;
  logic start_trigger, meas_valid, meas_timeout, busy;
  logic [SEL_W-1:0] sensor_sel, meas_sensor;
  logic [CNT_W-1:0] meas_count;
  logic [2:0] dbg_state;
  int n_vec = 0;
  int n_err = 0;

  always #25 clk = ~clk;

  echo_scan_scheduler #(
    .NUM_SENSORS(NS), .SEL_W(SEL_W), .CNT_W(CNT_W),
    .ECHO_TIMEOUT(TO), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .start_trigger(start_trigger), .trigger_done(trigger_done),
    .sensor_sel(sensor_sel), .echo_in(echo_in),
    .meas_valid(meas_valid), .meas_sensor(meas_sensor),
    .meas_count(meas_count), .meas_timeout(meas_timeout),
    .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_start_trigger"}, 32'(start_trigger), 0);
    check({tag, "_sensor_sel"},    32'(sensor_sel), 0);
    check({tag, "_meas_valid"},    32'(meas_valid), 0);
    check({tag, "_meas_sensor"},   32'(meas_sensor), 0);
    check({tag, "_meas_count"},    32'(meas_count), 0);
    check({tag, "_meas_timeout"},  32'(meas_timeout), 0);
    check({tag, "_busy"},          32'(busy), 0);
    check({tag, "_dbg_state"},     32'(dbg_state), 0);
  endtask

  // Synchronised echo level at WAIT_ECHO cycle t (t=0 is the cycle after the ack).
  function automatic logic lvl(input logic pre, input int fall_t, input int rise_t,
                               input int len, input int t);
    return (pre && t < fall_t) || (t >= rise_t && t < rise_t + len);
  endfunction

  // Reference: first rising edge before the last window cycle starts the pulse; a fall
  // before the last cycle completes it; otherwise timeout at cycle TO.
  function automatic void model_shot(input logic pre, input int fall_t, input int rise_t,
                                     input int len, output int v_at, output int cnt,
                                     output logic to);
    int r, f;
    logic prev;
    r = -1;
    f = -1;
    for (int t = 0; t < TO - 1 && r < 0; t++) begin
      prev = (t == 0) ? pre : lvl(pre, fall_t, rise_t, len, t - 1);
      if (lvl(pre, fall_t, rise_t, len, t) && !prev) r = t;
    end
    if (r < 0) begin
      v_at = TO; cnt = 0; to = 1'b1;
      return;
    end
    for (int t = r + 1; t < TO && f < 0; t++)
      if (!lvl(pre, fall_t, rise_t, len, t)) f = t;
    if (f >= 0 && f < TO - 1) begin
      v_at = f + 1; cnt = f - r; to = 1'b0;
    end else begin
      v_at = TO; cnt = ((f >= 0) ? f : TO) - r; to = 1'b1;
    end
    if (cnt > (1 << CNT_W) - 1) cnt = (1 << CNT_W) - 1;
  endfunction

  // driver: one full shot, trigger handshake through guard end
  task automatic shot(input logic pre, input int fall_t, input int rise_t, input int len,
                      input int drop_at, input int reset_at, input bit stray,
                      input int exp_sel);
    int v_at, e_cnt, pulses, waited;
    logic e_to, st_bad, sel_bad, en_end;
    model_shot(pre, fall_t, rise_t, len, v_at, e_cnt, e_to);
    echo_in = pre;
    waited = 0;
    while (start_trigger !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("trig_req", 32'(start_trigger), 1);
    if (start_trigger !== 1'b1) return;
    check("trig_sel", 32'(sensor_sel), 32'(exp_sel));
    repeat (ACK_DELAY) @(negedge clk);
    check("trig_hold", 32'(start_trigger), 1);
    trigger_done = 1'b1;
    @(negedge clk);
    trigger_done = 1'b0;
    check("trig_drop", 32'(start_trigger), 0);
    check("busy_run", 32'(busy), 1);
    pulses = 0; st_bad = 1'b0; sel_bad = 1'b0; en_end = 1'b1;
    for (int j = 0; j <= v_at + GC + 1; j++) begin
      if (j > 0) @(negedge clk);
      if (j == reset_at) begin
        reset = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check_idle_zero("abort");
        return;
      end
      echo_in = lvl(pre, fall_t, rise_t, len, j + 2);
      if (j == drop_at) begin
        enable = 1'b0;
        en_end = 1'b0;
      end
      trigger_done = stray && (j == v_at + 3);
      if (meas_valid === 1'b1) pulses++;
      if (j == v_at) begin
        check("valid_at", 32'(meas_valid), 1);
        check("meas_sensor", 32'(meas_sensor), 32'(exp_sel));
        check("meas_count", 32'(meas_count), 32'(e_cnt));
        check("meas_timeout", 32'(meas_timeout), 32'(e_to));
      end
      if (j <= v_at + GC) begin
        if (start_trigger !== 1'b0) st_bad = 1'b1;
        if (sensor_sel !== SEL_W'(exp_sel)) sel_bad = 1'b1;
      end
    end
    check("valid_pulses", 32'(pulses), 1);
    check("trig_quiet", 32'(st_bad), 0);
    check("sel_stable", 32'(sel_bad), 0);
    check("next_trig", 32'(start_trigger), 32'(en_end));
    check("busy_end", 32'(busy), 32'(en_end));
    check("next_sel", 32'(sensor_sel), 32'((exp_sel + 1) % NS));
    check("count_hold", 32'(meas_count), 32'(e_cnt));
    check("timeout_hold", 32'(meas_timeout), 32'(e_to));
  endtask

  initial begin
    int sel;
    logic p;
    reset = 1'b0; enable = 1'b0; trigger_done = 1'b0; echo_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_trig", 32'(start_trigger), 0);

    enable = 1'b1;
    shot(1'b0, 0, 30, 25, -1, -1, 1'b0, 0);   // clean echo, count 25
    shot(1'b0, 0, -1, 0, -1, -1, 1'b1, 1);    // no echo, stray ack in guard
    shot(1'b0, 0, 40, 90, -1, -1, 1'b0, 2);   // echo outlasts window, count 60
    shot(1'b1, 5, 20, 12, -1, -1, 1'b0, 0);   // high at entry, count 12
    shot(1'b0, 0, 15, 40, 20, -1, 1'b0, 1);   // enable dropped mid-measure
    repeat (5) @(negedge clk);
    check("stopped_busy", 32'(busy), 0);
    check("stopped_sel", 32'(sensor_sel), 2);
    check("stopped_trig", 32'(start_trigger), 0);

    enable = 1'b1;
    sel = 2;
    for (int k = 0; k < 11; k++) begin
      p = 1'($urandom_range(0, 1));
      shot(p, $urandom_range(2, 60), $urandom_range(2, 105), $urandom_range(1, 100),
           -1, -1, 1'($urandom_range(0, 1)), sel);
      sel = (sel + 1) % NS;
    end

    shot(1'b0, 0, 10, 60, -1, 20, 1'b0, sel);  // reset mid-measure
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_hold_valid", 32'(meas_valid), 0);
    end
    reset = 1'b1;
    enable = 1'b1;
    shot(1'b0, 0, 12, 30, -1, -1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
